// File: rtl/rx_fifo_unit_pkg.sv
// Shared definitions for the MiniUart receive FIFO: default geometry and the
// encodings of the capture FSM that handshakes with the receiving unit.
package rx_fifo_unit_pkg;

   localparam int unsigned RX_FIFO_DEPTH = 16;
   localparam int unsigned RX_FIFO_AW    = 4;

   typedef enum logic [1:0] {
      CAP_IDLE     = 2'd0,
      CAP_ACK      = 2'd1,
      CAP_WAIT_CLR = 2'd2
   } cap_state_e;

endpackage

// File: rtl/rx_fifo_ram.sv
// Storage array for the receive FIFO.
// Ports:
//   clk    - system clock
//   we     - write enable, writes wdata to mem[waddr] at the rising edge
//   waddr  - write address (FIFO write pointer)
//   wdata  - byte to store
//   raddr  - read address (FIFO read pointer)
//   rdata  - asynchronous read of mem[raddr] (first-word fall-through head)
module rx_fifo_ram #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/rx_fifo_unit.sv
// Receive buffer sitting directly behind the MiniUart receiving unit. Copies
// each received byte into a FIFO, acknowledges the receiver with a one-cycle
// rx_over_read pulse, and lets the CPU pop bytes at its own pace.
// Ports:
//   clk, rst      - system clock, synchronous active-high reset
//   rx_data       - receiving-unit data register
//   rx_rs         - receiving-unit byte-available status (asynchronous)
//   rx_over_read  - one-cycle pulse clearing the receiver's status
//   rd_en         - CPU pop strobe; rd_data is the FIFO head while !empty
//   empty, full   - occupancy flags; count is occupancy 0..DEPTH
//   flush         - empties the FIFO and clears overrun
//   ovr_clr       - clears overrun
//   overrun       - sticky: a byte arrived while the FIFO was full
//   irq           - (count >= IRQ_LEVEL) | overrun
module rx_fifo_unit
   import rx_fifo_unit_pkg::*;
#(
   parameter int unsigned DEPTH     = RX_FIFO_DEPTH,
   parameter int unsigned AW        = RX_FIFO_AW,
   parameter int unsigned IRQ_LEVEL = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_rs,
   output logic        rx_over_read,
   input  logic        rd_en,
   output logic [7:0]  rd_data,
   output logic        empty,
   output logic        full,
   output logic [AW:0] count,
   input  logic        flush,
   input  logic        ovr_clr,
   output logic        overrun,
   output logic        irq
);

   cap_state_e    state_q, state_d;
   logic          rs_meta_q, rs_meta_d;
   logic          rs_s_q, rs_s_d;
   logic          over_read_q, over_read_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;
   logic          overrun_q, overrun_d;

   logic          push;
   logic          do_pop;
   logic          do_push;
   logic          ovr_set;
   logic          ram_we;

   // Capture FSM. WAIT_CLR holds off until the synchronised status drops so a
   // receiver that is slow to clear rs is not captured twice.
   always_comb begin
      rs_meta_d   = rx_rs;
      rs_s_d      = rs_meta_q;
      state_d     = state_q;
      over_read_d = 1'b0;
      push        = 1'b0;
      unique case (state_q)
         CAP_IDLE: begin
            if (rs_s_q) begin
               push        = 1'b1;
               over_read_d = 1'b1;
               state_d     = CAP_ACK;
            end
         end
         CAP_ACK: begin
            state_d = CAP_WAIT_CLR;
         end
         CAP_WAIT_CLR: begin
            if (!rs_s_q) begin
               state_d = CAP_IDLE;
            end
         end
         default: begin
            state_d = CAP_IDLE;
         end
      endcase
   end

   assign empty = (count_q == '0);
   assign full  = (count_q == (AW+1)'(DEPTH));

   // A pop in the same cycle frees a slot, so a push into a full FIFO is
   // accepted rather than counted as overrun.
   always_comb begin
      do_pop    = rd_en & ~empty;
      do_push   = push & (~full | do_pop);
      ovr_set   = push & full & ~do_pop;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      count_d   = count_q;
      ram_we    = do_push & ~flush;
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + AW'(1);
         if (do_pop)  rptr_d = rptr_q + AW'(1);
         if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
         end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
         end
      end
      // Setting wins over a clear in the same cycle.
      overrun_d = ovr_set | (overrun_q & ~ovr_clr & ~flush);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= CAP_IDLE;
         rs_meta_q   <= 1'b0;
         rs_s_q      <= 1'b0;
         over_read_q <= 1'b0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rs_meta_q   <= rs_meta_d;
         rs_s_q      <= rs_s_d;
         over_read_q <= over_read_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         overrun_q   <= overrun_d;
      end
   end

   rx_fifo_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wptr_q),
      .wdata (rx_data),
      .raddr (rptr_q),
      .rdata (rd_data)
   );

   assign rx_over_read = over_read_q;
   assign count        = count_q;
   assign overrun      = overrun_q;
   assign irq          = (count_q >= (AW+1)'(IRQ_LEVEL)) | overrun_q;

endmodule

// File: tb/tb_rx_fifo_unit.sv
// Self-checking bench for rx_fifo_unit: scoreboard of captured bytes plus a
// small table of per-cycle control vectors and hand-written corner sequences.
module tb_rx_fifo_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_rs;
   logic       rx_over_read;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       flush;
   logic       ovr_clr;
   logic       overrun;
   logic       irq;

   int n_total = 0;
   int n_pass  = 0;
   logic [7:0] sb[$];

   typedef struct {
      bit rd_en;
      bit flush;
      bit ovr_clr;
      int exp_count;
      bit exp_empty;
      bit exp_overrun;
      bit exp_irq;
   } vec_t;
   vec_t vecs[5];

   rx_fifo_unit #(
      .DEPTH     (16),
      .AW        (4),
      .IRQ_LEVEL (1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_data      (rx_data),
      .rx_rs        (rx_rs),
      .rx_over_read (rx_over_read),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .empty        (empty),
      .full         (full),
      .count        (count),
      .flush        (flush),
      .ovr_clr      (ovr_clr),
      .overrun      (overrun),
      .irq          (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic pop_check(input string name);
      logic [7:0] e;
      if (sb.size() == 0) begin
         check({name, "_sb_underrun"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check(name, {24'd0, rd_data}, {24'd0, e});
      end
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic wait_over_read(input string name);
      int waited = 0;
      while (!rx_over_read && waited < 10) begin
         tick();
         waited++;
      end
      if (!rx_over_read) check({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic send_byte(input logic [7:0] d, input bit exp_push);
      rx_data = d;
      rx_rs   = 1'b1;
      if (exp_push) sb.push_back(d);
      wait_over_read("send");
      rx_rs = 1'b0;
      repeat (4) tick();
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      sb.delete();
   endtask

   initial begin
      int pulses;

      vecs[0] = '{rd_en:0, flush:0, ovr_clr:0, exp_count:5, exp_empty:0, exp_overrun:1, exp_irq:1};
      vecs[1] = '{rd_en:0, flush:1, ovr_clr:0, exp_count:0, exp_empty:1, exp_overrun:0, exp_irq:0};
      vecs[2] = '{rd_en:1, flush:0, ovr_clr:0, exp_count:0, exp_empty:1, exp_overrun:0, exp_irq:0};
      vecs[3] = '{rd_en:1, flush:0, ovr_clr:1, exp_count:0, exp_empty:1, exp_overrun:0, exp_irq:0};
      vecs[4] = '{rd_en:0, flush:0, ovr_clr:0, exp_count:0, exp_empty:1, exp_overrun:0, exp_irq:0};

      rst = 1'b1; rx_data = '0; rx_rs = 1'b0; rd_en = 1'b0; flush = 1'b0; ovr_clr = 1'b0;
      repeat (3) tick();
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_overrun", overrun, 0);
      check("rst_irq", irq, 0);
      check("rst_over_read", rx_over_read, 0);
      rst = 1'b0;
      tick();

      // 1: single byte, latency of three edges
      rx_data = 8'hA5; rx_rs = 1'b1; sb.push_back(8'hA5);
      tick();
      check("t1_or_n1", rx_over_read, 0);
      check("t1_cnt_n1", count, 0);
      tick();
      check("t1_or_n2", rx_over_read, 0);
      tick();
      check("t1_or_n3", rx_over_read, 1);
      check("t1_cnt_n3", count, 1);
      check("t1_empty", empty, 0);
      check("t1_irq", irq, 1);
      tick();
      check("t1_or_n4", rx_over_read, 0);
      rx_rs = 1'b0;
      repeat (4) tick();
      pop_check("t1_data");
      check("t1_empty_after", empty, 1);
      check("t1_irq_after", irq, 0);

      // 2: rs held high for 20 cycles
      rx_data = 8'h3C; rx_rs = 1'b1; sb.push_back(8'h3C);
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (rx_over_read) pulses++;
      end
      rx_rs = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (rx_over_read) pulses++;
      end
      check("t2_pulses", pulses, 1);
      check("t2_count", count, 1);
      pop_check("t2_data");

      // 3: 17 bytes into 16 entries
      for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
      send_byte(8'h10, 1'b0);
      check("t3_full", full, 1);
      check("t3_count", count, 16);
      check("t3_overrun", overrun, 1);
      check("t3_irq", irq, 1);
      for (int i = 0; i < 16; i++) pop_check("t3_data");
      check("t3_empty", empty, 1);
      check("t3_ovr_sticky", overrun, 1);
      ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
      check("t3_ovr_clr", overrun, 0);
      check("t3_irq_clr", irq, 0);

      // 4: full FIFO, pop coincides with capture
      for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i), 1'b1);
      check("t4_full_pre", full, 1);
      rx_data = 8'hEE; rx_rs = 1'b1;
      tick();
      tick();
      begin
         logic [7:0] e;
         e = sb.pop_front();
         check("t4_head", {24'd0, rd_data}, {24'd0, e});
      end
      sb.push_back(8'hEE);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("t4_or", rx_over_read, 1);
      check("t4_count", count, 16);
      check("t4_overrun", overrun, 0);
      check("t4_full", full, 1);
      rx_rs = 1'b0;
      repeat (4) tick();
      for (int i = 0; i < 16; i++) pop_check("t4_data");
      check("t4_empty", empty, 1);

      // overrun set beats ovr_clr in the same cycle
      for (int i = 0; i < 16; i++) send_byte(8'h60 + 8'(i), 1'b1);
      rx_data = 8'h77; rx_rs = 1'b1;
      tick();
      tick();
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      check("set_wins_ovr", overrun, 1);
      check("set_wins_cnt", count, 16);
      rx_rs = 1'b0;
      repeat (4) tick();
      do_flush();
      check("flush_cnt", count, 0);
      check("flush_ovr", overrun, 0);

      // 5: overflow, drain to 5, then table of control cycles
      for (int i = 0; i < 16; i++) send_byte(8'h40 + 8'(i), 1'b1);
      send_byte(8'h99, 1'b0);
      for (int i = 0; i < 11; i++) pop_check("t5_data");
      for (int v = 0; v < 5; v++) begin
         rd_en   = vecs[v].rd_en;
         flush   = vecs[v].flush;
         ovr_clr = vecs[v].ovr_clr;
         if (vecs[v].flush) begin
            sb.delete();
         end else if (vecs[v].rd_en && sb.size() > 0) begin
            logic [7:0] e;
            e = sb.pop_front();
            check($sformatf("vec%0d_data", v), {24'd0, rd_data}, {24'd0, e});
         end
         tick();
         rd_en = 1'b0; flush = 1'b0; ovr_clr = 1'b0;
         check($sformatf("vec%0d_count", v), count, vecs[v].exp_count);
         check($sformatf("vec%0d_empty", v), empty, vecs[v].exp_empty);
         check($sformatf("vec%0d_overrun", v), overrun, vecs[v].exp_overrun);
         check($sformatf("vec%0d_irq", v), irq, vecs[v].exp_irq);
      end

      // 6: reset one cycle after rx_over_read, rs still high
      rx_data = 8'h6B; rx_rs = 1'b1;
      wait_over_read("t6");
      check("t6_cnt_pre", count, 1);
      rst = 1'b1;
      tick();
      check("t6_rst_count", count, 0);
      check("t6_rst_empty", empty, 1);
      check("t6_rst_or", rx_over_read, 0);
      check("t6_rst_irq", irq, 0);
      check("t6_rst_ovr", overrun, 0);
      rst = 1'b0;
      sb.delete();
      sb.push_back(8'h6B);
      tick();
      check("t6_or_r1", rx_over_read, 0);
      tick();
      check("t6_or_r2", rx_over_read, 0);
      check("t6_cnt_r2", count, 0);
      tick();
      check("t6_or_r3", rx_over_read, 1);
      check("t6_cnt_r3", count, 1);
      rx_rs = 1'b0;
      repeat (4) tick();
      pop_check("t6_data");
      check("t6_empty", empty, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
